// File: rtl/ysyx_23060187_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_ifu -- instruction fetch unit
//
// Issues one instruction-memory request at a time. It waits for the response,
// then holds the fetched word for the decoder until the decoder accepts it.
// A redirect from execute (jal/jalr/taken branch) replaces the fetch PC. Any
// request already accepted by memory when the redirect arrives is dropped.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_req_valid  fetch request present (REQ state)
//   imem_req_addr   word-aligned fetch address
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  instruction word returned
//   imem_rsp_data   returned instruction word
//   redirect_valid  control-flow change from execute
//   redirect_pc     redirect target (low two bits ignored)
//   inst_valid      instruction presented to the decoder
//   inst_ready      decoder consumes the instruction this cycle
//   inst, inst_pc   instruction word and its address
//   opcode/fun3/fun7 fields inst[6:0], inst[14:12], inst[31:25]
//   fetch_cnt       number of instructions handed to the decoder (wraps)
// ----------------------------------------------------------------------------
module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  fun3,
  output logic [6:0]  fun7,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_seq_pc;
  logic        w_unused;

  // r_pc is only ever loaded with aligned values, so it can drive the
  // request address directly.
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_seq_pc      = r_inst_pc + 32'd4;
  assign w_unused      = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC_ALIGNED;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_fetch_cnt  <= 32'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            // Memory took the old address this cycle. Its response must be
            // swallowed before the redirected fetch can go out.
            if (imem_req_ready) begin
              r_drop  <= 1'b1;
              r_state <= S_WAIT;
            end
          end else if (imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            // A response in the same cycle closes the outstanding request,
            // so nothing is left to drop. Otherwise remember to drop it.
            if (imem_rsp_valid) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst       <= imem_rsp_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_OUT;
            end
          end
        end

        S_OUT: begin
          // A redirect takes priority over a decoder handshake in the same
          // cycle. The instruction was on the wrong path, so it is not counted.
          if (redirect_valid) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end else if (inst_ready) begin
            r_pc         <= w_seq_pc;
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end

        default: begin
          r_inst_valid <= 1'b0;
          r_state      <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign opcode         = r_inst[6:0];
  assign fun3           = r_inst[14:12];
  assign fun7           = r_inst[31:25];
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
module tb_ysyx_23060187_ifu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default reset PC
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [6:0]  i_opcode;
  logic [2:0]  i_fun3;
  logic [6:0]  i_fun7;
  logic [31:0] i_cnt;

  // DUT B: reset PC at the top of the address space
  logic        b_rst_n;
  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_redir_valid;
  logic [31:0] b_redir_pc;
  logic        b_i_valid;
  logic        b_i_ready;
  logic [31:0] b_i_inst;
  logic [31:0] b_i_pc;
  logic [6:0]  b_i_opcode;
  logic [2:0]  b_i_fun3;
  logic [6:0]  b_i_fun7;
  logic [31:0] b_i_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060187_ifu dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc),
    .inst_valid(i_valid), .inst_ready(i_ready), .inst(i_inst), .inst_pc(i_pc),
    .opcode(i_opcode), .fun3(i_fun3), .fun7(i_fun7), .fetch_cnt(i_cnt)
  );

  ysyx_23060187_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr), .imem_req_ready(b_req_ready),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redir_valid), .redirect_pc(b_redir_pc),
    .inst_valid(b_i_valid), .inst_ready(b_i_ready), .inst(b_i_inst), .inst_pc(b_i_pc),
    .opcode(b_i_opcode), .fun3(b_i_fun3), .fun7(b_i_fun7), .fetch_cnt(b_i_cnt)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %0h want 0", i_valid); end
    n_tests++; if (i_inst !== 32'd0) begin n_fail++; $display("FAIL rst_inst: got %h want 00000000", i_inst); end
    n_tests++; if (i_pc !== 32'd0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 00000000", i_pc); end
    n_tests++; if (i_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_fetch_cnt: got %h want 00000000", i_cnt); end
    n_tests++; if ({i_opcode, i_fun3, i_fun7} !== 17'd0) begin n_fail++; $display("FAIL rst_fields: got %h want 0", {i_opcode, i_fun3, i_fun7}); end
    step();
    step();
    rst_n = 1'b1;
    n_tests++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rel_req_valid: got %0h want 1", req_valid); end
    n_tests++; if (req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rel_req_addr: got %h want 80000000", req_addr); end
  endtask

  task automatic test_basic_fetch();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL wait_req_valid: got %0h want 0", req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL basic_inst_valid: got %0h want 1", i_valid); end
    n_tests++; if (i_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_inst: got %h want 00000013", i_inst); end
    n_tests++; if (i_opcode !== 7'h13) begin n_fail++; $display("FAIL basic_opcode: got %h want 13", i_opcode); end
    n_tests++; if (i_fun3 !== 3'd0) begin n_fail++; $display("FAIL basic_fun3: got %h want 0", i_fun3); end
    n_tests++; if (i_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_inst_pc: got %h want 80000000", i_pc); end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++; if (i_valid !== 1'b1 || i_inst !== 32'h0000_0013 || i_pc !== 32'h8000_0000)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0h inst=%h pc=%h want v=1 inst=00000013 pc=80000000", k, i_valid, i_inst, i_pc); end
      n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_req[%0d]: got %0h want 0", k, req_valid); end
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_tests++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next_req_valid: got %0h want 1", req_valid); end
    n_tests++; if (req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_next_addr: got %h want 80000004", req_addr); end
    n_tests++; if (i_cnt !== 32'd1) begin n_fail++; $display("FAIL stall_fetch_cnt: got %0d want 1", i_cnt); end
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL stall_inst_valid_low: got %0h want 0", i_valid); end
  endtask

  task automatic test_decode_fields();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h4000_5033;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_opcode !== 7'h33) begin n_fail++; $display("FAIL dec_opcode: got %h want 33", i_opcode); end
    n_tests++; if (i_fun3 !== 3'd5) begin n_fail++; $display("FAIL dec_fun3: got %h want 5", i_fun3); end
    n_tests++; if (i_fun7 !== 7'h20) begin n_fail++; $display("FAIL dec_fun7: got %h want 20", i_fun7); end
    n_tests++; if (i_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL dec_inst_pc: got %h want 80000004", i_pc); end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_tests++; if (i_cnt !== 32'd2) begin n_fail++; $display("FAIL dec_fetch_cnt: got %0d want 2", i_cnt); end
    n_tests++; if (req_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL dec_next_addr: got %h want 80000008", req_addr); end
  endtask

  task automatic test_redirect_wait();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    redir_valid = 1'b1; redir_pc = 32'h8000_0102;
    step();
    redir_valid = 1'b0;
    n_tests++; if (req_valid !== 1'b0 || i_valid !== 1'b0) begin n_fail++; $display("FAIL rw_still_wait: got req=%0h inst_valid=%0h want 0 0", req_valid, i_valid); end
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rw_discard: got inst_valid=%0h want 0", i_valid); end
    n_tests++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rw_req_valid: got %0h want 1", req_valid); end
    n_tests++; if (req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_addr: got %h want 80000100", req_addr); end
    n_tests++; if (i_cnt !== 32'd2) begin n_fail++; $display("FAIL rw_fetch_cnt: got %0d want 2", i_cnt); end
  endtask

  task automatic test_redirect_out();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b1 || i_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL ro_out: got v=%0h pc=%h want v=1 pc=80000100", i_valid, i_pc); end
    i_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h8000_1000;
    step();
    i_ready = 1'b0; redir_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL ro_inst_valid: got %0h want 0", i_valid); end
    n_tests++; if (i_cnt !== 32'd2) begin n_fail++; $display("FAIL ro_fetch_cnt: got %0d want 2", i_cnt); end
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL ro_addr: got v=%0h addr=%h want v=1 addr=80001000", req_valid, req_addr); end
  endtask

  task automatic test_redirect_req();
    // Redirect coincides with an accepted request, then a second redirect while waiting.
    req_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h8000_2000;
    step();
    req_ready = 1'b0; redir_pc = 32'h8000_3000;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rq_to_wait: got req_valid=%0h want 0", req_valid); end
    step();
    redir_valid = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rq_drop: got inst_valid=%0h want 0", i_valid); end
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_3000) begin n_fail++; $display("FAIL rq_last_wins: got v=%0h addr=%h want v=1 addr=80003000", req_valid, req_addr); end
    // Redirect in REQ without ready: stays in REQ with the new address.
    redir_valid = 1'b1; redir_pc = 32'h8000_4003;
    step();
    redir_valid = 1'b0;
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_4000) begin n_fail++; $display("FAIL rq_stay: got v=%0h addr=%h want v=1 addr=80004000", req_valid, req_addr); end
    // Redirect in WAIT with the response in the same cycle.
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    redir_valid = 1'b1; redir_pc = 32'h8000_5000; rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    redir_valid = 1'b0; rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_5000)
      begin n_fail++; $display("FAIL rq_same_cycle_rsp: got iv=%0h rv=%0h addr=%h want iv=0 rv=1 addr=80005000", i_valid, req_valid, req_addr); end
  endtask

  task automatic test_rsp_ignored();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0 || req_valid !== 1'b1) begin n_fail++; $display("FAIL ign_rsp: got iv=%0h rv=%0h want iv=0 rv=1", i_valid, req_valid); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rm_async: got v=%0h addr=%h want v=1 addr=80000000", req_valid, req_addr); end
    n_tests++; if (i_cnt !== 32'd0) begin n_fail++; $display("FAIL rm_fetch_cnt: got %0d want 0", i_cnt); end
    #2 rst_n = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_rsp: got inst_valid=%0h want 0", i_valid); end
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rm_req: got v=%0h addr=%h want v=1 addr=80000000", req_valid, req_addr); end
    // Reset while an instruction is held for the decoder.
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h4000_5033;
    step();
    rsp_valid = 1'b0;
    n_tests++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL rm_out: got inst_valid=%0h want 1", i_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (i_valid !== 1'b0 || i_inst !== 32'd0 || i_pc !== 32'd0 || i_fun7 !== 7'd0)
      begin n_fail++; $display("FAIL rm_out_clear: got v=%0h inst=%h pc=%h fun7=%h want all 0", i_valid, i_inst, i_pc, i_fun7); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_pc_wrap();
    b_rst_n = 1'b1;
    n_tests++; if (b_req_valid !== 1'b1 || b_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got v=%0h addr=%h want v=1 addr=fffffffc", b_req_valid, b_req_addr); end
    b_req_ready = 1'b1;
    step();
    b_req_ready = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_data = 32'h0000_0013;
    step();
    b_rsp_valid = 1'b0;
    n_tests++; if (b_i_valid !== 1'b1 || b_i_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_out: got v=%0h pc=%h want v=1 pc=fffffffc", b_i_valid, b_i_pc); end
    b_i_ready = 1'b1;
    step();
    b_i_ready = 1'b0;
    n_tests++; if (b_req_valid !== 1'b1 || b_req_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr: got v=%0h addr=%h want v=1 addr=00000000", b_req_valid, b_req_addr); end
    n_tests++; if (b_i_cnt !== 32'd1) begin n_fail++; $display("FAIL wrap_fetch_cnt: got %0d want 1", b_i_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
    redir_valid = 1'b0; redir_pc = 32'd0; i_ready = 1'b0;
    b_rst_n = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'd0;
    b_redir_valid = 1'b0; b_redir_pc = 32'd0; b_i_ready = 1'b0;

    test_reset();
    test_basic_fetch();
    test_stall();
    test_decode_fields();
    test_redirect_wait();
    test_redirect_out();
    test_redirect_req();
    test_rsp_ignored();
    test_reset_mid();
    test_pc_wrap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
